// File: rtl/deserializer.sv
// deserializer: gathers FACTOR consecutive valid WIDTH-bit words into one frame.
// The first word received (w_1) lands in out[WIDTH-1:0]. This matches the
// serializer's input layout, so a serializer/deserializer pair passes data
// through unchanged.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in         serial data word
//   in_valid   in carries a word this cycle (gaps allowed)
//   in_first   marks in as w_1 of a frame (only used when USE_FIRST=1)
//   out        assembled frame, held until the next completion
//   out_valid  one-cycle pulse when a new frame appears on out
//   frame_err  one-cycle pulse on an alignment violation (USE_FIRST=1 only)

// One assembly slot: a word register loaded when its slot index is addressed.
module deser_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (we) q <= d;
    end
endmodule

module deserializer #(
    parameter int WIDTH     = 32,
    parameter int FACTOR    = 2,
    parameter int USE_FIRST = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        in,
    input  logic                    in_valid,
    input  logic                    in_first,
    output logic [WIDTH*FACTOR-1:0] out,
    output logic                    out_valid,
    output logic                    frame_err
);
    localparam int            CW   = $clog2(FACTOR) + 1;
    localparam logic [CW-1:0] LAST = CW'(FACTOR - 1);

    typedef enum logic {SYNC, COLLECT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, idx;
    logic          accept, start, complete, err;

    // Slots 1..FACTOR-1 are registered. The last slot is the live input word,
    // so the completing word goes straight into out and needs no storage.
    logic [FACTOR-1:0][WIDTH-1:0] slot;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        start   = 1'b0;
        err     = 1'b0;
        if (in_valid) begin
            if (USE_FIRST == 0) begin
                accept = 1'b1;
            end else if (state_q == SYNC) begin
                // Words are dropped silently until a marked frame start arrives.
                if (in_first) begin
                    accept  = 1'b1;
                    start   = 1'b1;
                    state_d = COLLECT;
                end
            end else if (in_first) begin
                // A marker in mid-frame drops the partial frame and restarts here.
                accept = 1'b1;
                start  = 1'b1;
                err    = (cnt_q != '0);
            end else if (cnt_q == '0) begin
                // A frame start without its marker: discard it and resynchronise.
                err     = 1'b1;
                state_d = SYNC;
            end else begin
                accept = 1'b1;
            end
        end
        idx      = start ? '0 : cnt_q;
        complete = accept && (idx == LAST);
        if (accept) cnt_d = complete ? '0 : idx + 1'b1;
    end

    for (genvar k = 0; k < FACTOR - 1; k++) begin : g_slot
        deser_slot #(.WIDTH(WIDTH)) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (accept && (idx == CW'(k))),
            .d     (in),
            .q     (slot[k])
        );
    end
    assign slot[FACTOR-1] = in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= (USE_FIRST != 0) ? SYNC : COLLECT;
            cnt_q     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_valid <= complete;
            frame_err <= err;
            if (complete) out <= slot;
        end
    end
endmodule

// File: tb/tb_deserializer.sv
module tb_deserializer;
    localparam int W = 8;
    localparam int F = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // dut0: F=4 counting only; dut1: F=4 marker aligned; dut2: F=1
    logic [W-1:0]   in0, in1, in2;
    logic           v0, v1, v2, f0, f1, f2;
    logic [W*F-1:0] o0, o1;
    logic [W-1:0]   o2;
    logic           ov0, ov1, ov2, fe0, fe1, fe2;

    deserializer #(.WIDTH(W), .FACTOR(F), .USE_FIRST(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in(in0), .in_valid(v0), .in_first(f0),
        .out(o0), .out_valid(ov0), .frame_err(fe0));
    deserializer #(.WIDTH(W), .FACTOR(F), .USE_FIRST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in(in1), .in_valid(v1), .in_first(f1),
        .out(o1), .out_valid(ov1), .frame_err(fe1));
    deserializer #(.WIDTH(W), .FACTOR(1), .USE_FIRST(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .in(in2), .in_valid(v2), .in_first(f2),
        .out(o2), .out_valid(ov2), .frame_err(fe2));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: a frame is simply the list of words received so far.
    logic [W-1:0]   q0[$], q1[$];
    bit             sync1;
    logic [W*F-1:0] eo0, eo1;
    logic [W-1:0]   eo2;
    bit             ev0, ev1, ev2, ee1;
    int             pulses0;

    function automatic logic [W*F-1:0] pack(input logic [W-1:0] q[$]);
        logic [W*F-1:0] r = '0;
        for (int i = 0; i < q.size(); i++) r[i*W +: W] = q[i];
        return r;
    endfunction

    task automatic model_reset();
        q0.delete(); q1.delete();
        sync1 = 0;
        eo0 = '0; eo1 = '0; eo2 = '0;
        ev0 = 0; ev1 = 0; ev2 = 0; ee1 = 0;
    endtask

    task automatic idle();
        v0 = 0; v1 = 0; v2 = 0; f0 = 0; f1 = 0; f2 = 0;
    endtask

    // Called at a negedge with inputs already driven. It predicts the outputs
    // that follow the next rising edge, checks them, and returns at the next negedge.
    task automatic step();
        ev0 = 0; ev1 = 0; ev2 = 0; ee1 = 0;
        if (v0) begin
            q0.push_back(in0);
            if (q0.size() == F) begin eo0 = pack(q0); ev0 = 1; q0.delete(); end
        end
        if (v1) begin
            if (!sync1) begin
                if (f1) begin sync1 = 1; q1.delete(); q1.push_back(in1); end
            end else if (f1) begin
                if (q1.size() > 0) ee1 = 1;
                q1.delete(); q1.push_back(in1);
            end else if (q1.size() == 0) begin
                ee1 = 1; sync1 = 0;
            end else begin
                q1.push_back(in1);
            end
            if (q1.size() == F) begin eo1 = pack(q1); ev1 = 1; q1.delete(); end
        end
        if (v2) begin eo2 = in2; ev2 = 1; end
        @(posedge clk); #1;
        chk("ov0", ov0, ev0); chk("o0", o0, eo0); chk("fe0", fe0, 0);
        chk("ov1", ov1, ev1); chk("o1", o1, eo1); chk("fe1", fe1, ee1);
        chk("ov2", ov2, ev2); chk("o2", o2, eo2); chk("fe2", fe2, 0);
        if (ov0) pulses0++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        #1;
        model_reset();
        chk("rst_o0", o0, 0); chk("rst_o1", o1, 0); chk("rst_o2", o2, 0);
        chk("rst_ov", {ov0, ov1, ov2}, 0); chk("rst_fe", {fe0, fe1, fe2}, 0);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic w0(input logic [W-1:0] d);
        idle(); v0 = 1; in0 = d; step();
    endtask

    task automatic w1(input logic [W-1:0] d, input bit first);
        idle(); v1 = 1; in1 = d; f1 = first; step();
    endtask

    initial begin
        idle();
        in0 = '0; in1 = '0; in2 = '0;
        pulses0 = 0;
        rst_n = 0;
        model_reset();
        #1;
        chk("rst_o0", o0, 0); chk("rst_ov0", ov0, 0); chk("rst_fe1", fe1, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // continuous frame
        w0(8'h11); w0(8'h22); w0(8'h33); w0(8'h44);
        chk("tp1_out", o0, 32'h44332211); chk("tp1_vld", ov0, 1);
        idle(); step();
        chk("tp1_pulse_len", ov0, 0);

        // gaps between words
        w0(8'hA1); idle(); repeat (3) step();
        w0(8'hA2); idle(); step();
        w0(8'hA3); w0(8'hA4);
        chk("tp2_out", o0, 32'hA4A3A2A1); chk("tp2_vld", ov0, 1);
        idle(); step();

        // back-to-back frames at full rate, as a serializer would produce them
        pulses0 = 0;
        for (int n = 0; n < 8; n++) begin
            w0(8'hEF); w0(8'hBE); w0(8'hAD); w0(8'hDE);
            chk("tp3_out", o0, 32'hDEADBEEF); chk("tp3_vld", ov0, 1);
        end
        idle(); step();
        chk("tp3_pulses", pulses0, 8);

        // mid-frame marker drops the partial frame
        w1(8'h01, 1); w1(8'h02, 0); w1(8'h03, 1);
        chk("tp4_err", fe1, 1);
        w1(8'h04, 0); w1(8'h05, 0); w1(8'h06, 0);
        chk("tp4_out", o1, 32'h06050403); chk("tp4_vld", ov1, 1);
        idle(); step();

        // unmarked word after reset is dropped; unmarked frame start resyncs
        do_reset();
        w1(8'h99, 0);
        chk("tp5_noerr", fe1, 0);
        w1(8'h10, 1); w1(8'h20, 0); w1(8'h30, 0); w1(8'h40, 0);
        chk("tp5_out", o1, 32'h40302010); chk("tp5_vld", ov1, 1);
        w1(8'h55, 0);
        chk("tp5_err", fe1, 1);
        w1(8'h66, 0);
        chk("tp5_sync_noerr", fe1, 0);
        idle(); step();

        // reset mid-frame loses the partial frame and clears out
        w0(8'hC1); w0(8'hC2);
        do_reset();
        w0(8'h01); w0(8'h02); w0(8'h03); w0(8'h04);
        chk("tp6_out", o0, 32'h04030201); chk("tp6_vld", ov0, 1);
        idle(); step();

        // FACTOR=1 with continuous input
        for (int i = 0; i < 4; i++) begin
            idle(); v2 = 1; in2 = W'(8'h30 + i); step();
            chk("f1_out", o2, W'(8'h30 + i)); chk("f1_vld", ov2, 1);
        end

        // random traffic on all three instances
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                v0 = ($urandom_range(0, 9) < 7); in0 = W'($urandom);
                f0 = 1'($urandom);
                v1 = ($urandom_range(0, 9) < 8); in1 = W'($urandom);
                f1 = ($urandom_range(0, 4) == 0);
                v2 = 1'($urandom); in2 = W'($urandom);
                f2 = 1'($urandom);
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
